// File: rtl/fas_pipline5_if.sv
// Handshake bundle between the normaliser, the final pack stage and the consumer.
// The slave modport is the pack stage's view; master is the surrounding pipeline.
interface fas_pipline5_if;
    logic [32:0] x4;
    logic [8:0]  base_ei;
    logic        enable;
    logic        in_ready;
    logic [31:0] result;
    logic        flag_of;
    logic        flag_uf;
    logic        flag_zero;
    logic        out_valid;
    logic        out_ready;
    logic        drop_err;

    modport slave (
        input  x4, base_ei, enable, out_ready,
        output in_ready, result, flag_of, flag_uf, flag_zero, out_valid, drop_err
    );

    modport master (
        output x4, base_ei, enable, out_ready,
        input  in_ready, result, flag_of, flag_uf, flag_zero, out_valid, drop_err
    );
endinterface

// File: rtl/fas_pipline5.sv
// Final float add/sub stage: packs sign/exponent/significand into an IEEE-754
// single, classifies overflow/underflow/zero, and buffers results in a small FIFO.
module fas_pipline5 #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic           clk,
    input  logic           rst,
    fas_pipline5_if.slave  bus
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [8:0]  w_e;
    logic [31:0] w_s;
    logic        w_sign;
    logic [31:0] w_res;
    logic        w_of;
    logic        w_uf;
    logic        w_zero;
    logic [34:0] w_entry;

    assign w_e    = bus.base_ei;
    assign w_s    = bus.x4[31:0];
    assign w_sign = bus.x4[32];

    // Priority matters: exponents 384..511 are negative wraps from subtraction,
    // so they must be caught before the plain overflow range.
    always_comb begin
        w_res  = 32'h0;
        w_of   = 1'b0;
        w_uf   = 1'b0;
        w_zero = 1'b0;
        if (w_e[8] && (w_e >= 9'd384)) begin
            w_res  = {w_sign, 31'h0};
            w_uf   = 1'b1;
            w_zero = 1'b1;
        end else if (w_e >= 9'd255) begin
            w_res = {w_sign, 8'hFF, 23'h0};
            w_of  = 1'b1;
        end else if ((w_e == 9'd0) || !w_s[23]) begin
            w_res  = {w_sign, 31'h0};
            w_zero = 1'b1;
            w_uf   = (w_s != 32'h0);
        end else begin
            w_res = {w_sign, w_e[7:0], w_s[22:0]};
        end
    end

    assign w_entry = {w_res, w_of, w_uf, w_zero};

    logic [34:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_drop_err;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [34:0]      w_head;

    assign w_in_ready  = (r_count != FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    // No bypass when full: a pop in the same cycle does not free a slot for this enable.
    assign w_push      = bus.enable & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= w_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (bus.enable && !w_in_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Stale array contents are masked so an empty FIFO always presents zeros.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : 35'h0;

    assign bus.result    = w_head[34:3];
    assign bus.flag_of   = w_head[2];
    assign bus.flag_uf   = w_head[1];
    assign bus.flag_zero = w_head[0];
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.drop_err  = r_drop_err;

endmodule
